vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the 640x480@60 VGA timing generator: consumes hsync/vsync plus a pixel-rate strobe and recovers pixel coordinates, line/frame strobes and a lock indication.
- Checks sync period, pulse width and H/V phase against the parameterised timing.
- Sits in front of capture/overlay logic, and in loopback self-test to verify generator output.

---
 rtl/vga_sync_decoder.sv | 156 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers x/y from hsync/vsync on pixel strobes,
// checks sync period, pulse width and H/V phase, and reports lock.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_SEARCH | no timing reference, waiting for a clean vsync fall
// ST_VERIFY | counting consecutive error-free frames toward lock
// ST_LOCKED | timing trusted; valid/newline/newframe enabled
module vga_sync_decoder #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic       hsync_n,
   input  logic       vsync_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       valid,
   output logic       newline,
   output logic       newframe,
   output logic       locked,
   output logic       h_err,
   output logic       v_err
);

   localparam logic [9:0]  X_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]  Y_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  X_HFALL  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  Y_VFALL  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] HPER_OK  = 11'(H_TOTAL);
   localparam logic [10:0] HPER_MAX = 11'(2 * H_TOTAL);
   localparam logic [10:0] HLOW_OK  = 11'(H_SYNC);
   localparam logic [9:0]  VPER_OK  = 10'(V_TOTAL);
   localparam logic [9:0]  VLOW_OK  = 10'(V_SYNC);
   localparam logic [3:0]  GOOD_LOCK = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

   state_t      state;
   logic        hs_prev, vs_prev;
   logic        h_seen, v_seen;
   logic [10:0] hper, hlow;
   logic [9:0]  vcnt, vlow;
   logic [3:0]  good;

   logic        hs_fall, hs_rise, vs_fall, vs_rise;
   logic        x_wrap, h_bad, v_bad, err;
   logic [9:0]  x_nxt, y_nxt;

   assign hs_fall = hs_prev & ~hsync_n;
   assign hs_rise = ~hs_prev & hsync_n;
   assign vs_fall = vs_prev & ~vsync_n;
   assign vs_rise = ~vs_prev & vsync_n;

   assign x_wrap = ~hs_fall & (x == X_LAST);
   assign x_nxt  = hs_fall ? X_HFALL : (x_wrap ? 10'd0 : x + 10'd1);
   assign y_nxt  = vs_fall ? Y_VFALL
                 : (x_wrap ? ((y == Y_LAST) ? 10'd0 : y + 10'd1) : y);

   // Watchdog fires only on the tick that brings the period counter to saturation.
   assign h_bad = (hs_fall & h_seen & ((hper + 11'd1) != HPER_OK))
                | (hs_rise & (hlow != HLOW_OK))
                | (~hs_fall & h_seen & (hper == HPER_MAX - 11'd1));
   assign v_bad = (vs_fall & ((v_seen & (vcnt != VPER_OK)) | (x_nxt != 10'd0)))
                | (vs_rise & (vlow != VLOW_OK));
   assign err   = h_bad | v_bad;

   assign valid = locked & (x < X_ACT) & (y < Y_ACT);

   always_ff @(posedge clk) begin
      newline  <= 1'b0;
      newframe <= 1'b0;
      h_err    <= 1'b0;
      v_err    <= 1'b0;
      if (rst) begin
         state   <= ST_SEARCH;
         hs_prev <= 1'b1;
         vs_prev <= 1'b1;
         h_seen  <= 1'b0;
         v_seen  <= 1'b0;
         hper    <= '0;
         hlow    <= '0;
         vcnt    <= '0;
         vlow    <= '0;
         good    <= '0;
         x       <= '0;
         y       <= '0;
         locked  <= 1'b0;
      end else if (pix_en) begin
         hs_prev  <= hsync_n;
         vs_prev  <= vsync_n;
         h_seen   <= h_seen | hs_fall;
         v_seen   <= v_seen | vs_fall;
         x        <= x_nxt;
         y        <= y_nxt;
         h_err    <= h_bad;
         v_err    <= v_bad;
         newline  <= locked & x_wrap;
         newframe <= locked & x_wrap & (y_nxt == 10'd0);

         if (hs_fall)                hper <= '0;
         else if (hper != HPER_MAX)  hper <= hper + 11'd1;

         if (hs_fall)                          hlow <= 11'd1;
         else if (!hsync_n && hlow != '1)      hlow <= hlow + 11'd1;

         // A coincident hsync fall belongs to the frame that starts at this vsync fall.
         if (vs_fall)                          vcnt <= {9'd0, hs_fall};
         else if (hs_fall && vcnt != '1)       vcnt <= vcnt + 10'd1;

         if (vs_fall)                          vlow <= {9'd0, hs_fall};
         else if (hs_fall && !vsync_n && vlow != '1)
                                               vlow <= vlow + 10'd1;

         case (state)
            ST_SEARCH: begin
               if (vs_fall && !err) begin
                  state <= ST_VERIFY;
                  good  <= '0;
               end
            end
            ST_VERIFY: begin
               if (err) begin
                  state <= ST_SEARCH;
               end else if (vs_fall) begin
                  if (good + 4'd1 == GOOD_LOCK) begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                  end else begin
                     good <= good + 4'd1;
                  end
               end
            end
            ST_LOCKED: begin
               if (err) begin
                  state  <= ST_SEARCH;
                  locked <= 1'b0;
               end
            end
            default: state <= ST_SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down timing (16x10 total) so many frames fit
// in a short run; a bench-side source generator drives ideal and faulted frames.
module tb_vga_sync_decoder;
   localparam int HA = 8, HFP = 2, HS = 3, HT = 16;
   localparam int VA = 6, VFP = 1, VS = 2, VT = 10, LF = 2;

   logic       clk = 1'b0;
   logic       rst, pix_en, hsync_n, vsync_n;
   logic [9:0] x, y;
   logic       valid, newline, newframe, locked, h_err, v_err;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT), .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
      .x(x), .y(y), .valid(valid), .newline(newline), .newframe(newframe),
      .locked(locked), .h_err(h_err), .v_err(v_err)
   );

   typedef struct {
      int mode;   // 0 ideal, 1 long line, 2 short hsync, 3 short frame, 4 vsync phase, 5 long hsync, 6 reset
      int herr;
      int verr;
      int lk1;
      int lk2;
      int lk3;
   } vec_t;

   vec_t vecs[7];

   int n_tests = 0, n_fail = 0;
   int cnt_h, cnt_v, cnt_nl, cnt_nf, cnt_valid, nf_bad;
   int trk_bad = 0, drop_bad = 0, frame_no = 0;
   int lock_frame = -1, lock_y = -1, lock_x = -1;
   bit lock_seen = 1'b0, track_on = 1'b0;
   logic locked_q = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      cnt_h = 0; cnt_v = 0; cnt_nl = 0; cnt_nf = 0; cnt_valid = 0; nf_bad = 0;
   endtask

   task automatic drive_pix(input logic hs, input logic vs, input int sx, input int sy);
      @(negedge clk);
      pix_en = 1'b1; hsync_n = hs; vsync_n = vs;
      @(negedge clk);
      pix_en = 1'b0;
      if (h_err) cnt_h++;
      if (v_err) cnt_v++;
      if ((h_err || v_err) && locked) drop_bad++;
      if (newline) cnt_nl++;
      if (newframe) begin
         cnt_nf++;
         if (sx != 0 || sy != 0) nf_bad++;
      end
      if (valid) cnt_valid++;
      if (track_on && locked && (int'(x) != sx || int'(y) != sy)) trk_bad++;
      if (locked && !locked_q && !lock_seen) begin
         lock_seen = 1'b1; lock_frame = frame_no; lock_y = sy; lock_x = sx;
      end
      locked_q = locked;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1; pix_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_x", int'(x), 0);
      chk("rst_mid_y", int'(y), 0);
      chk("rst_mid_locked", int'(locked), 0);
      chk("rst_mid_pulses", int'({newline, newframe, h_err, v_err}), 0);
      chk("rst_mid_valid", int'(valid), 0);
      locked_q = 1'b0;
   endtask

   task automatic gen_frame(input int mode);
      track_on = (mode == 0);
      for (int yy = 0; yy < VT; yy++) begin
         int len; int hw; int vst;
         if (mode == 3 && yy == 2) continue;
         len = (mode == 1 && yy == 3) ? HT + 1 : HT;
         hw  = HS;
         if (mode == 2 && yy == 3) hw = HS - 1;
         if (mode == 5 && yy == 3) hw = HS + 1;
         vst = (VA + VFP) * HT + ((mode == 4) ? 5 : 0);
         for (int xx = 0; xx < len; xx++) begin
            int p;
            p = yy * HT + xx;
            if (mode == 6 && yy == 4 && xx == 3) reset_pulse();
            drive_pix(!(xx >= HA + HFP && xx < HA + HFP + hw),
                      !(p >= vst && p < vst + VS * HT), xx, yy);
         end
      end
      frame_no++;
   endtask

   initial begin
      int first_k;
      vecs[0] = '{0, 0, 0, 1, 1, 1};
      vecs[1] = '{1, 1, 0, 0, 1, 1};
      vecs[2] = '{2, 1, 0, 0, 1, 1};
      vecs[3] = '{5, 1, 0, 0, 1, 1};
      vecs[4] = '{3, 0, 1, 0, 0, 1};
      vecs[5] = '{4, 0, 1, 0, 0, 1};
      vecs[6] = '{6, 0, 0, 0, 1, 1};

      rst = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_pulses", int'({newline, newframe, h_err, v_err}), 0);
      chk("rst_valid", int'(valid), 0);
      rst = 1'b0;

      // Lock acquisition: third vsync fall (frame 2, line 7, pixel 0)
      clear_counts();
      repeat (3) gen_frame(0);
      chk("lock_frame", lock_frame, 2);
      chk("lock_y", lock_y, VA + VFP);
      chk("lock_x", lock_x, 0);
      chk("acq_herr", cnt_h, 0);
      chk("acq_verr", cnt_v, 0);

      clear_counts();
      gen_frame(0);
      chk("f_valid_px", cnt_valid, HA * VA);
      chk("f_newframe", cnt_nf, 1);
      chk("f_newframe_pos", nf_bad, 0);
      chk("f_newline", cnt_nl, VT);
      chk("f_herr", cnt_h, 0);
      chk("f_verr", cnt_v, 0);
      chk("f_track", trk_bad, 0);
      chk("f_locked", int'(locked), 1);

      for (int i = 0; i < 7; i++) begin
         clear_counts();
         gen_frame(vecs[i].mode);
         gen_frame(0);
         chk($sformatf("m%0d_lock1", vecs[i].mode), int'(locked), vecs[i].lk1);
         gen_frame(0);
         chk($sformatf("m%0d_lock2", vecs[i].mode), int'(locked), vecs[i].lk2);
         gen_frame(0);
         chk($sformatf("m%0d_lock3", vecs[i].mode), int'(locked), vecs[i].lk3);
         chk($sformatf("m%0d_herr", vecs[i].mode), cnt_h, vecs[i].herr);
         chk($sformatf("m%0d_verr", vecs[i].mode), cnt_v, vecs[i].verr);
      end

      // Watchdog: hsync held high after the last fall at line 9, pixel 10.
      // 5 ticks remain in that line, so the 2*HT-th tick is held pixel 27.
      clear_counts();
      track_on = 1'b0;
      first_k = -1;
      for (int k = 1; k <= 40; k++) begin
         drive_pix(1'b1, 1'b1, -1, -1);
         if (h_err && first_k < 0) first_k = k;
      end
      chk("wd_count", cnt_h, 1);
      chk("wd_tick", first_k, 2 * HT - 5);
      chk("wd_locked", int'(locked), 0);
      chk("wd_verr", cnt_v, 0);

      // Recovery: first fall sees a saturated period and flags once more.
      clear_counts();
      repeat (4) gen_frame(0);
      chk("rec_herr", cnt_h, 1);
      chk("rec_verr", cnt_v, 0);
      chk("rec_locked", int'(locked), 1);

      chk("track_total", trk_bad, 0);
      chk("lock_drop", drop_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
